// File: rtl/stable_matching_pkg.sv
// Shared types and width helpers for the stable-matching checker.
// The optional STABLE_CHECK_COUNT_EN feature is handled in the top module.
package stable_matching_pkg;

   function automatic int log2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

   localparam int SM_N       = 10;
   localparam int SM_LOG_N   = log2(SM_N);
   localparam int SM_POS_W   = log2(SM_N + 1);

   typedef enum logic [2:0] {
      IDLE,
      PERM,
      RANK,
      SCAN,
      DONE
   } state_t;

endpackage

// File: rtl/stable_matching_checker_rank_lookup.sv
// First-match priority search: index of key in a packed list, or N when absent.
module rank_lookup
   import stable_matching_pkg::*;
#(
   parameter int N  = SM_N,
   parameter int W  = SM_LOG_N,
   parameter int PW = SM_POS_W
) (
   input  logic [N*W-1:0] list,
   input  logic [W-1:0]   key,
   output logic [PW-1:0]  pos
);

   always_comb begin
      pos = PW'(N);
      for (int j = N - 1; j >= 0; j--) begin
         if (list[j*W +: W] == key) pos = PW'(j);
      end
   end

endmodule

// File: rtl/stable_matching_checker.sv
// Sequential verifier for a matching: permutation check, rank table build, blocking-pair scan.
// Optional macro STABLE_CHECK_COUNT_EN adds block_cnt and forces a full scan.
//
// state | meaning
// IDLE  | waiting for start; results held
// PERM  | one matched pair per cycle, checks partner range and uniqueness
// RANK  | one index per cycle, records each side's rank of its partner
// SCAN  | one (s, k) preference entry per cycle, tests for a blocking pair
// DONE  | publishes results with a one-cycle done pulse
module stable_matching_checker
   import stable_matching_pkg::*;
#(
   parameter  int Kr    = SM_N,
   parameter  int Ks    = SM_N,
   parameter  int S     = SM_N,
   parameter  int R     = SM_N,
   localparam int LOG_S = log2(S),
   localparam int LOG_R = log2(R),
   localparam int G_W   = R*Kr*LOG_S + S*Ks*LOG_R
`ifdef STABLE_CHECK_COUNT_EN
   , localparam int CNT_W = log2(S*Ks + 1)
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [G_W-1:0]   g,
   input  logic [R*LOG_S-1:0] o,
   output logic             busy,
   output logic             done,
   output logic             valid_match,
   output logic             stable,
   output logic [LOG_S-1:0] block_s,
   output logic [LOG_R-1:0] block_r
`ifdef STABLE_CHECK_COUNT_EN
   , output logic [CNT_W-1:0] block_cnt
`endif
);

   localparam int LOG_K = log2(Ks);
   localparam int PKR   = log2(Kr + 1);
   localparam int PKS   = log2(Ks + 1);

   state_t             state;
   logic [G_W-1:0]     g_reg;
   logic [R*LOG_S-1:0] o_reg;
   logic [S-1:0]       seen;
   logic [LOG_R-1:0]   s_partner [S];
   logic [PKS-1:0]     rank_s [S];
   logic [PKR-1:0]     rank_r [R];
   logic [LOG_S-1:0]   idx;
   logic [LOG_S-1:0]   scan_s;
   logic [LOG_K-1:0]   scan_k;
   logic               match_ok;
   logic               no_block;

   logic [LOG_S*Kr-1:0] r_row [R];
   logic [LOG_R*Ks-1:0] s_row [S];
   logic [LOG_S-1:0]    partner [R];

   for (genvar r = 0; r < R; r++) begin : g_r_rows
      assign r_row[r]   = g_reg[LOG_S*Kr*r +: LOG_S*Kr];
      assign partner[r] = o_reg[LOG_S*r +: LOG_S];
   end
   for (genvar s = 0; s < S; s++) begin : g_s_rows
      assign s_row[s] = g_reg[R*Kr*LOG_S + LOG_R*Ks*s +: LOG_R*Ks];
   end

   logic [LOG_S-1:0] perm_p;
   logic             perm_bad;
   assign perm_p   = partner[idx];
   assign perm_bad = (int'(perm_p) >= S) || seen[perm_p];

   logic [PKS-1:0] rank_s_pos;
   logic [PKR-1:0] rank_r_pos;
   logic [PKR-1:0] scan_pos;
   logic [LOG_R-1:0] scan_r;
   logic [LOG_R-1:0] r_sel;
   logic             r_ok;
   logic             blocking;
   logic             scan_last;

   assign scan_r    = s_row[scan_s][LOG_R*scan_k +: LOG_R];
   assign r_ok      = int'(scan_r) < R;
   // out-of-range preference entries must not index the rank tables
   assign r_sel     = r_ok ? scan_r : '0;
   assign blocking  = (PKS'(scan_k) < rank_s[scan_s]) && r_ok && (scan_pos < rank_r[r_sel]);
   assign scan_last = (int'(scan_s) == S - 1) && (int'(scan_k) == Ks - 1);

   rank_lookup #(.N(Ks), .W(LOG_R), .PW(PKS)) u_rank_s (
      .list (s_row[idx]),
      .key  (s_partner[idx]),
      .pos  (rank_s_pos)
   );

   rank_lookup #(.N(Kr), .W(LOG_S), .PW(PKR)) u_rank_r (
      .list (r_row[idx]),
      .key  (partner[idx]),
      .pos  (rank_r_pos)
   );

   rank_lookup #(.N(Kr), .W(LOG_S), .PW(PKR)) u_scan_pos (
      .list (r_row[r_sel]),
      .key  (scan_s),
      .pos  (scan_pos)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         g_reg       <= '0;
         o_reg       <= '0;
         seen        <= '0;
         s_partner   <= '{default: '0};
         rank_s      <= '{default: '0};
         rank_r      <= '{default: '0};
         idx         <= '0;
         scan_s      <= '0;
         scan_k      <= '0;
         match_ok    <= 1'b0;
         no_block    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         valid_match <= 1'b0;
         stable      <= 1'b0;
         block_s     <= '0;
         block_r     <= '0;
`ifdef STABLE_CHECK_COUNT_EN
         block_cnt   <= '0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  g_reg       <= g;
                  o_reg       <= o;
                  seen        <= '0;
                  idx         <= '0;
                  scan_s      <= '0;
                  scan_k      <= '0;
                  match_ok    <= 1'b1;
                  no_block    <= 1'b1;
                  busy        <= 1'b1;
                  valid_match <= 1'b0;
                  stable      <= 1'b0;
                  block_s     <= '0;
                  block_r     <= '0;
`ifdef STABLE_CHECK_COUNT_EN
                  block_cnt   <= '0;
`endif
                  state       <= PERM;
               end
            end
            PERM: begin
               if (perm_bad) begin
                  match_ok <= 1'b0;
                  state    <= DONE;
               end else begin
                  seen[perm_p]      <= 1'b1;
                  s_partner[perm_p] <= LOG_R'(idx);
                  if (int'(idx) == R - 1) begin
                     idx   <= '0;
                     state <= RANK;
                  end else begin
                     idx <= idx + LOG_S'(1);
                  end
               end
            end
            RANK: begin
               rank_s[idx] <= rank_s_pos;
               rank_r[idx] <= rank_r_pos;
               if (int'(idx) == S - 1) begin
                  idx   <= '0;
                  state <= SCAN;
               end else begin
                  idx <= idx + LOG_S'(1);
               end
            end
            SCAN: begin
               if (blocking) begin
                  if (no_block) begin
                     block_s <= scan_s;
                     block_r <= scan_r;
                  end
                  no_block <= 1'b0;
`ifdef STABLE_CHECK_COUNT_EN
                  block_cnt <= block_cnt + CNT_W'(1);
`endif
               end
               if (int'(scan_k) == Ks - 1) begin
                  scan_k <= '0;
                  scan_s <= scan_s + LOG_S'(1);
               end else begin
                  scan_k <= scan_k + LOG_K'(1);
               end
`ifdef STABLE_CHECK_COUNT_EN
               if (scan_last) state <= DONE;
`else
               if (scan_last || blocking) state <= DONE;
`endif
            end
            DONE: begin
               done        <= 1'b1;
               busy        <= 1'b0;
               valid_match <= match_ok;
               stable      <= match_ok & no_block;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
